matmul_tile_scheduler: RTL and testbench
========================================

Name: matmul_tile_scheduler

Overview:
- Sequences the 4x4 systolic matrix-multiply unit over a job of N tiles.
- Per tile: clears the unit, runs it for a fixed cycle budget, then offers the finished tile to a downstream consumer through a valid/ready handshake.
- Advances the input and output BRAM base addresses by programmable strides between tiles.
- Sits between the PS-side register file (job descriptor, start, abort, interrupt) and the matmul unit wrapper.

Parameters:
- TILE_CYCLES, 20, cycles unit_run is held high per tile (covers feed, compute and 4-row write-back); legal range 1..255.
- ADDR_W, 8, width of BRAM addresses.
- CNT_W, 8, width of the tile counter and the cycle counter.

Ports:
- clk  in  1  single system clock, all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- cfg_start  in  1  one-cycle pulse to launch a job; ignored while busy=1.
- cfg_abort  in  1  one-cycle pulse to abandon the job.
- cfg_num_tiles  in  CNT_W  tiles in the job; 0 means an empty job.
- cfg_din_base  in  ADDR_W  input base address of tile 0.
- cfg_dout_base  in  ADDR_W  output base address of tile 0.
- cfg_din_stride  in  ADDR_W  input address increment per tile.
- cfg_dout_stride  in  ADDR_W  output address increment per tile.
- irq_clr  in  1  clears irq.
- busy  out  1  high from the cycle after an accepted start until return to IDLE.
- done  out  1  one-cycle pulse when a job completes or is aborted.
- aborted  out  1  one-cycle pulse, coincident with done, on an abort only.
- irq  out  1  sticky; set with done, cleared by irq_clr.
- unit_clr  out  1  one-cycle clear of the matmul unit's counters and address registers.
- unit_run  out  1  run enable for the unit; the wrapper inverts it to the unit's active-low enable.
- unit_din_base  out  ADDR_W  input base address of the current tile.
- unit_dout_base  out  ADDR_W  output base address of the current tile.
- tile_idx  out  CNT_W  index of the current tile.
- tile_valid  out  1  current tile result is ready in BRAM.
- tile_ready  in  1  consumer accepts the tile.

Behaviour:
- All outputs are registered.
- Reset values: every output 0, including the address and index outputs; state IDLE; cycle counter 0.
- States: IDLE, CLR, RUN, HAND, DONE.
- IDLE:
  - cfg_start with cfg_num_tiles!=0: latch the entire descriptor; tile_idx<=0; unit_din_base<=cfg_din_base; unit_dout_base<=cfg_dout_base; go to CLR; busy=1 from the next cycle.
  - cfg_start with cfg_num_tiles==0: go to DONE directly; busy stays 0; no unit activity.
- CLR: unit_clr=1 for exactly 1 cycle; go to RUN with cycle counter 0.
- RUN:
  - unit_run=1; the cycle counter increments each cycle.
  - When counter==TILE_CYCLES-1, go to HAND. unit_run is high for exactly TILE_CYCLES cycles.
- HAND:
  - unit_run=0; tile_valid=1, held until a cycle with tile_ready=1.
  - tile_valid, tile_idx and both base addresses stay stable while waiting.
  - On handshake with tile_idx==num_tiles-1: go to DONE.
  - On any other handshake: tile_idx++; each base address += its stride; go to CLR.
  - tile_valid drops the cycle after the handshake.
- DONE: done=1 and irq<=1 for one cycle; go to IDLE.
- Address arithmetic is modulo 2^ADDR_W; wrap-around is silent, no error.
- Timing with tile_ready tied high and start sampled at cycle 0:
  - tile k: CLR at cycle 1+22k, RUN at cycles 2+22k..21+22k, HAND at 22+22k.
  - Per-tile period is TILE_CYCLES+2 cycles.
- Abort:
  - cfg_abort in any non-IDLE state: next state DONE with aborted=1; unit_run=0 and tile_valid=0 immediately, counters frozen.
  - cfg_abort in IDLE is ignored.
  - If abort and a handshake occur in the same cycle, abort wins.
- Simultaneous irq_clr and irq set: set wins.
- cfg_start while busy: ignored; the latched descriptor is not modified.
- rst mid-job: all state returns to reset values asynchronously; no done pulse.

Decomposition:
- Shared package matmul_ctrl_pkg holds:
  - state encoding constants (IDLE=0, CLR=1, RUN=2, HAND=3, DONE=4);
  - the default TILE_CYCLES value;
  - the address width constants, shared with the matmul unit wrapper.
- One natural sub-module, matmul_tile_addr_gen: holds the base-address registers, applies the load and stride-advance operations, and wraps modulo 2^ADDR_W.

Test Plan:
- num_tiles=3, din_base=0x00/stride 0x10, dout_base=0x80/stride 0x40, tile_ready=1 -> tile_valid at cycles 22, 44, 66 with addresses (0x00,0x80), (0x10,0xC0), (0x20,0x00 wrapped); done and irq at cycle 67; unit_run high for exactly 20 cycles per tile.
- num_tiles=1, tile_ready held 0 for 5 cycles after tile_valid -> tile_valid high for 6 cycles with tile_idx=0 stable; done one cycle after the handshake.
- num_tiles=0 start -> done at cycle 1; unit_clr and unit_run never asserted; busy stays 0.
- num_tiles=4, cfg_abort during tile 1 RUN -> unit_run low the next cycle; done and aborted pulse together; no further tile_valid; tile_idx stays 1.
- cfg_start repeated mid-job with a different descriptor -> ignored; tile addresses follow the first descriptor.
- rst asserted during HAND of tile 2 -> all outputs 0 asynchronously; a following start with num_tiles=1 completes normally at cycle 23.

Source files
------------

// File: rtl/matmul_ctrl_pkg.sv
// Shared constants and state encoding for the matmul tile scheduler and unit wrapper.
package matmul_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_RUN  = 3'd2,
    ST_HAND = 3'd3,
    ST_DONE = 3'd4
  } sched_state_e;

  localparam int unsigned TILE_CYCLES_DEFAULT = 20;
  localparam int unsigned MM_ADDR_W           = 8;
  localparam int unsigned MM_CNT_W            = 8;

endpackage

// File: rtl/matmul_tile_addr_gen.sv
// Per-tile BRAM base address registers: load at job start, advance by stride between tiles.
module matmul_tile_addr_gen
  import matmul_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = MM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] din_base,
  input  logic [ADDR_W-1:0] dout_base,
  input  logic [ADDR_W-1:0] din_stride,
  input  logic [ADDR_W-1:0] dout_stride,
  output logic [ADDR_W-1:0] din_addr,
  output logic [ADDR_W-1:0] dout_addr
);

  logic [ADDR_W-1:0] din_stride_q;
  logic [ADDR_W-1:0] dout_stride_q;

  // Strides are captured with the bases so a mid-job descriptor change cannot leak in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din_addr      <= '0;
      dout_addr     <= '0;
      din_stride_q  <= '0;
      dout_stride_q <= '0;
    end else if (load) begin
      din_addr      <= din_base;
      dout_addr     <= dout_base;
      din_stride_q  <= din_stride;
      dout_stride_q <= dout_stride;
    end else if (advance) begin
      din_addr  <= din_addr + din_stride_q;
      dout_addr <= dout_addr + dout_stride_q;
    end
  end

endmodule

// File: rtl/matmul_tile_scheduler.sv
// Job-level sequencer for the 4x4 systolic matmul unit: clear, run, hand off each tile.
module matmul_tile_scheduler
  import matmul_ctrl_pkg::*;
#(
  parameter int unsigned TILE_CYCLES = TILE_CYCLES_DEFAULT,
  parameter int unsigned ADDR_W      = MM_ADDR_W,
  parameter int unsigned CNT_W       = MM_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic [CNT_W-1:0]  cfg_num_tiles,
  input  logic [ADDR_W-1:0] cfg_din_base,
  input  logic [ADDR_W-1:0] cfg_dout_base,
  input  logic [ADDR_W-1:0] cfg_din_stride,
  input  logic [ADDR_W-1:0] cfg_dout_stride,
  input  logic              irq_clr,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              irq,
  output logic              unit_clr,
  output logic              unit_run,
  output logic [ADDR_W-1:0] unit_din_base,
  output logic [ADDR_W-1:0] unit_dout_base,
  output logic [CNT_W-1:0]  tile_idx,
  output logic              tile_valid,
  input  logic              tile_ready
);

  sched_state_e     state_q, state_d;
  logic [CNT_W-1:0] num_tiles_q;
  logic [CNT_W-1:0] cyc_q;
  logic             latch;
  logic             advance;
  logic             abort_ok;

  always_comb begin
    state_d  = state_q;
    latch    = 1'b0;
    advance  = 1'b0;
    abort_ok = cfg_abort &&
               (state_q == ST_CLR || state_q == ST_RUN || state_q == ST_HAND);
    unique case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          if (cfg_num_tiles != '0) begin
            state_d = ST_CLR;
            latch   = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_CLR:  state_d = ST_RUN;
      ST_RUN: begin
        if (cyc_q == CNT_W'(TILE_CYCLES - 1)) state_d = ST_HAND;
      end
      ST_HAND: begin
        if (tile_ready) begin
          if (tile_idx == num_tiles_q - CNT_W'(1)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_CLR;
            advance = 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Abort overrides any handshake in the same cycle and freezes counters.
    if (abort_ok) begin
      state_d = ST_DONE;
      advance = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      num_tiles_q <= '0;
      cyc_q       <= '0;
      tile_idx    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      irq         <= 1'b0;
      unit_clr    <= 1'b0;
      unit_run    <= 1'b0;
      tile_valid  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (latch) begin
        num_tiles_q <= cfg_num_tiles;
        tile_idx    <= '0;
      end else if (advance) begin
        tile_idx <= tile_idx + CNT_W'(1);
      end
      if (state_q == ST_CLR) cyc_q <= '0;
      else if (state_q == ST_RUN && state_d == ST_RUN) cyc_q <= cyc_q + CNT_W'(1);
      // Outputs are registered from the next state so they align with the state they describe.
      unique case (state_q)
        ST_IDLE: busy <= latch;
        ST_DONE: busy <= 1'b0;
        default: busy <= 1'b1;
      endcase
      done       <= (state_d == ST_DONE);
      aborted    <= abort_ok;
      unit_clr   <= (state_d == ST_CLR);
      unit_run   <= (state_d == ST_RUN);
      tile_valid <= (state_d == ST_HAND);
      if (state_d == ST_DONE) irq <= 1'b1;
      else if (irq_clr)       irq <= 1'b0;
    end
  end

  matmul_tile_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk         (clk),
    .rst         (rst),
    .load        (latch),
    .advance     (advance),
    .din_base    (cfg_din_base),
    .dout_base   (cfg_dout_base),
    .din_stride  (cfg_din_stride),
    .dout_stride (cfg_dout_stride),
    .din_addr    (unit_din_base),
    .dout_addr   (unit_dout_base)
  );

endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// Directed bench for matmul_tile_scheduler with hand-computed cycle and address expectations.
module tb_matmul_tile_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_start = 1'b0;
  logic       cfg_abort = 1'b0;
  logic [7:0] cfg_num_tiles = '0;
  logic [7:0] cfg_din_base = '0;
  logic [7:0] cfg_dout_base = '0;
  logic [7:0] cfg_din_stride = '0;
  logic [7:0] cfg_dout_stride = '0;
  logic       irq_clr = 1'b0;
  logic       busy, done, aborted, irq, unit_clr, unit_run, tile_valid;
  logic [7:0] unit_din_base, unit_dout_base, tile_idx;
  logic       tile_ready = 1'b1;

  matmul_tile_scheduler #(
    .TILE_CYCLES (20),
    .ADDR_W      (8),
    .CNT_W       (8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_start       (cfg_start),
    .cfg_abort       (cfg_abort),
    .cfg_num_tiles   (cfg_num_tiles),
    .cfg_din_base    (cfg_din_base),
    .cfg_dout_base   (cfg_dout_base),
    .cfg_din_stride  (cfg_din_stride),
    .cfg_dout_stride (cfg_dout_stride),
    .irq_clr         (irq_clr),
    .busy            (busy),
    .done            (done),
    .aborted         (aborted),
    .irq             (irq),
    .unit_clr        (unit_clr),
    .unit_run        (unit_run),
    .unit_din_base   (unit_din_base),
    .unit_dout_base  (unit_dout_base),
    .tile_idx        (tile_idx),
    .tile_valid      (tile_valid),
    .tile_ready      (tile_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int         cyc;
  int         nvalid, valid_cnt, done_cyc, abort_cyc, run_since, clr_cnt, busy_cnt;
  int         vcyc[8];
  int         run_seg[8];
  logic [7:0] vdin[8];
  logic [7:0] vdout[8];
  logic [7:0] vidx[8];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_log();
    nvalid = 0; valid_cnt = 0; done_cyc = -1; abort_cyc = -1;
    run_since = 0; clr_cnt = 0; busy_cnt = 0;
  endtask

  task automatic sample();
    if (unit_run) run_since++;
    if (unit_clr) clr_cnt++;
    if (busy) busy_cnt++;
    if (done) done_cyc = cyc;
    if (aborted) abort_cyc = cyc;
    if (tile_valid) begin
      valid_cnt++;
      if (nvalid < 8) begin
        vcyc[nvalid]    = cyc;
        vdin[nvalid]    = unit_din_base;
        vdout[nvalid]   = unit_dout_base;
        vidx[nvalid]    = tile_idx;
        run_seg[nvalid] = run_since;
        nvalid++;
      end
      run_since = 0;
    end
  endtask

  task automatic run_to(input int c);
    while (cyc < c) begin
      tick();
      sample();
    end
  endtask

  // Start is sampled at the edge ending cycle 0; returns observing cycle 1.
  task automatic start_job(input logic [7:0] n, input logic [7:0] db, input logic [7:0] ob,
                           input logic [7:0] ds, input logic [7:0] os);
    clear_log();
    cfg_num_tiles = n; cfg_din_base = db; cfg_dout_base = ob;
    cfg_din_stride = ds; cfg_dout_stride = os;
    cfg_start = 1'b1;
    cyc = 0;
    tick();
    cfg_start = 1'b0;
    sample();
  endtask

  initial begin
    cyc = 0;
    clear_log();
    tick(); tick();
    check_eq("reset_outputs", {busy, done, aborted, irq, unit_clr, unit_run, tile_valid,
             unit_din_base, unit_dout_base, tile_idx}, 32'h0);
    rst = 1'b0;
    tick();

    // Three tiles, dout wraps on the third
    start_job(8'd3, 8'h00, 8'h80, 8'h10, 8'h40);
    check_eq("t1_busy_c1", busy, 1);
    check_eq("t1_clr_c1", unit_clr, 1);
    run_to(68);
    check_eq("t1_nvalid", nvalid, 3);
    check_eq("t1_vcyc0", vcyc[0], 22);
    check_eq("t1_vcyc1", vcyc[1], 44);
    check_eq("t1_vcyc2", vcyc[2], 66);
    check_eq("t1_addr0", {vdin[0], vdout[0], vidx[0]}, 32'h008000);
    check_eq("t1_addr1", {vdin[1], vdout[1], vidx[1]}, 32'h10C001);
    check_eq("t1_addr2", {vdin[2], vdout[2], vidx[2]}, 32'h200002);
    check_eq("t1_run0", run_seg[0], 20);
    check_eq("t1_run1", run_seg[1], 20);
    check_eq("t1_run2", run_seg[2], 20);
    check_eq("t1_clr_cnt", clr_cnt, 3);
    check_eq("t1_done_cyc", done_cyc, 67);
    check_eq("t1_no_abort", abort_cyc, -1);
    check_eq("t1_irq", irq, 1);
    check_eq("t1_busy_end", busy, 0);
    irq_clr = 1'b1; tick(); irq_clr = 1'b0;
    check_eq("t1_irq_clr", irq, 0);

    // Consumer stalls five cycles; irq_clr collides with the set
    tile_ready = 1'b0;
    start_job(8'd1, 8'h30, 8'h40, 8'h01, 8'h01);
    run_to(27);
    check_eq("t2_vcyc0", vcyc[0], 22);
    tile_ready = 1'b1;
    irq_clr = 1'b1;
    run_to(28);
    check_eq("t2_valid_cnt", valid_cnt, 6);
    check_eq("t2_idx_first", vidx[0], 0);
    check_eq("t2_idx_last", {vidx[5], vdin[5], vdout[5]}, 32'h003040);
    check_eq("t2_done_cyc", done_cyc, 28);
    check_eq("t2_valid_drop", tile_valid, 0);
    irq_clr = 1'b0;
    check_eq("t2_irq_set_wins", irq, 1);
    irq_clr = 1'b1; tick(); irq_clr = 1'b0;
    check_eq("t2_irq_cleared", irq, 0);

    // Abort in IDLE is ignored
    cfg_abort = 1'b1; tick(); cfg_abort = 1'b0;
    check_eq("idle_abort", {done, aborted, busy}, 0);

    // Empty job
    start_job(8'd0, 8'h11, 8'h22, 8'h01, 8'h01);
    check_eq("t3_done_c1", done, 1);
    run_to(5);
    check_eq("t3_done_cyc", done_cyc, 1);
    check_eq("t3_no_unit", {clr_cnt[7:0], run_since[7:0]}, 0);
    check_eq("t3_busy_cnt", busy_cnt, 0);
    check_eq("t3_irq", irq, 1);
    irq_clr = 1'b1; tick(); irq_clr = 1'b0;

    // Abort during tile 1 RUN
    start_job(8'd4, 8'h04, 8'h08, 8'h01, 8'h02);
    run_to(30);
    check_eq("t4_run_before", {unit_run, tile_idx, unit_din_base}, {1'b1, 8'd1, 8'h05});
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    sample();
    check_eq("t4_run_low", unit_run, 0);
    check_eq("t4_done_aborted", {done, aborted}, 2'b11);
    check_eq("t4_idx", tile_idx, 1);
    run_to(90);
    check_eq("t4_valid_cnt", valid_cnt, 1);
    check_eq("t4_after", {busy, tile_idx, unit_din_base, unit_dout_base}, {1'b0, 8'd1, 8'h05, 8'h0A});
    irq_clr = 1'b1; tick(); irq_clr = 1'b0;

    // Restart mid-job with a different descriptor
    start_job(8'd2, 8'h10, 8'h20, 8'h01, 8'h02);
    run_to(5);
    cfg_num_tiles = 8'd5; cfg_din_base = 8'h99; cfg_dout_base = 8'h77;
    cfg_din_stride = 8'h33; cfg_dout_stride = 8'h44;
    cfg_start = 1'b1;
    run_to(6);
    cfg_start = 1'b0;
    run_to(50);
    check_eq("t5_nvalid", nvalid, 2);
    check_eq("t5_tile0", {vcyc[0][7:0], vdin[0], vdout[0]}, {8'd22, 8'h10, 8'h20});
    check_eq("t5_tile1", {vcyc[1][7:0], vdin[1], vdout[1]}, {8'd44, 8'h11, 8'h22});
    check_eq("t5_done_cyc", done_cyc, 45);

    // Reset during HAND of tile 2, then a normal one-tile job
    start_job(8'd3, 8'h00, 8'h00, 8'h08, 8'h08);
    run_to(66);
    check_eq("t6_hand2", {tile_valid, tile_idx}, {1'b1, 8'd2});
    #2 rst = 1'b1;
    #1;
    check_eq("t6_async_rst", {busy, done, aborted, irq, unit_clr, unit_run, tile_valid,
             unit_din_base, unit_dout_base, tile_idx}, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    check_eq("t6_no_done", {done, busy}, 0);
    start_job(8'd1, 8'h40, 8'h50, 8'h01, 8'h01);
    run_to(25);
    check_eq("t6_vcyc", vcyc[0], 22);
    check_eq("t6_done_cyc", done_cyc, 23);
    check_eq("t6_nvalid", nvalid, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
